// File: rtl/rw_regfile.sv
// rw_regfile: 16 x 32-bit register file with write-back bypass and a
// per-register pending scoreboard that raises stall for operands that are
// still in flight.
module rw_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_FFFC,
    parameter logic [3:0]  RA_IDX  = 4'd15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  a1,
    input  logic [3:0]  a2,
    output logic [31:0] d1,
    output logic [31:0] d2,
    input  logic        wb_valid,
    input  logic        IsWb,
    input  logic        IsLd,
    input  logic        IsCall,
    input  logic [3:0]  Rd,
    input  logic [31:0] aluResult,
    input  logic [31:0] ldResult,
    input  logic [31:0] PC_WB,
    input  logic        iss_valid,
    input  logic        iss_wr,
    input  logic [3:0]  iss_rd,
    output logic        stall
);

    logic [31:0] r_regs [16];
    logic [15:0] r_pending;

    logic        w_we;
    logic [3:0]  w_waddr;
    logic [31:0] w_wdata;
    logic        w_hit1;
    logic        w_hit2;
    logic [15:0] w_pending_nxt;

    // Write-back decode; gated by reset_n so the bypass path also shows
    // reset values while reset is held.
    always_comb begin
        w_we    = reset_n & wb_valid & (IsWb | IsCall);
        w_waddr = IsCall ? RA_IDX : Rd;
        if (IsCall)
            w_wdata = PC_WB + 32'd4;
        else if (IsLd)
            w_wdata = ldResult;
        else
            w_wdata = aluResult;
    end

    // Combinational read ports with same-cycle bypass of the write-back value.
    always_comb begin
        w_hit1 = w_we & (w_waddr == a1);
        w_hit2 = w_we & (w_waddr == a2);
        d1     = w_hit1 ? w_wdata : r_regs[a1];
        d2     = w_hit2 ? w_wdata : r_regs[a2];
    end

    // An operand stalls only if pending and not being produced this cycle.
    always_comb begin
        stall = (r_pending[a1] & ~w_hit1) | (r_pending[a2] & ~w_hit2);
    end

    // Scoreboard next state: clear retiring write first, then set the newly
    // issued destination so a younger issue to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_we)
            w_pending_nxt[w_waddr] = 1'b0;
        if (iss_valid && iss_wr)
            w_pending_nxt[iss_rd] = 1'b1;
    end

    // Register storage; r14 comes out of reset holding the stack pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                r_regs[i] <= (i == 14) ? SP_INIT : 32'd0;
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    // Pending scoreboard register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pending <= 16'd0;
        else
            r_pending <= w_pending_nxt;
    end

endmodule

// File: tb/tb_rw_regfile.sv
// tb_rw_regfile: directed vectors; the stimulus pushes hand-computed
// expectations into a queue and a negedge monitor pops and compares them.
module tb_rw_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  a1, a2;
    logic [31:0] d1, d2;
    logic        wb_valid, IsWb, IsLd, IsCall;
    logic [3:0]  Rd;
    logic [31:0] aluResult, ldResult, PC_WB;
    logic        iss_valid, iss_wr;
    logic [3:0]  iss_rd;
    logic        stall;

    typedef struct {
        string       nm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        st;
    } exp_t;

    exp_t exp_q[$];
    logic obs_valid = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    rw_regfile dut (
        .clk(clk), .reset_n(reset_n), .a1(a1), .a2(a2), .d1(d1), .d2(d2),
        .wb_valid(wb_valid), .IsWb(IsWb), .IsLd(IsLd), .IsCall(IsCall),
        .Rd(Rd), .aluResult(aluResult), .ldResult(ldResult), .PC_WB(PC_WB),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd), .stall(stall)
    );

    always #5 clk = ~clk;

    // Monitor: one observation per flagged cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (obs_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_obs: no expectation queued, d1=%h d2=%h stall=%b", d1, d2, stall);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (d1 !== e.d1 || d2 !== e.d2 || stall !== e.st) begin
                    n_bad++;
                    $display("FAIL %s: got d1=%h d2=%h stall=%b, want d1=%h d2=%h stall=%b",
                             e.nm, d1, d2, stall, e.d1, e.d2, e.st);
                end
            end
        end
    end

    // Start a new cycle: just after the rising edge, idle all controls.
    task automatic cyc();
        @(posedge clk);
        #1;
        obs_valid = 1'b0;
        wb_valid = 0; IsWb = 0; IsLd = 0; IsCall = 0; Rd = 0;
        aluResult = 0; ldResult = 0; PC_WB = 0;
        iss_valid = 0; iss_wr = 0; iss_rd = 0;
    endtask

    task automatic expect_out(string nm, logic [31:0] e1, logic [31:0] e2, logic es);
        exp_t e;
        e.nm = nm; e.d1 = e1; e.d2 = e2; e.st = es;
        exp_q.push_back(e);
        obs_valid = 1'b1;
    endtask

    task automatic wb(logic [3:0] rd, logic [31:0] v);
        wb_valid = 1; IsWb = 1; Rd = rd; aluResult = v;
    endtask

    task automatic issue(logic [3:0] rd);
        iss_valid = 1; iss_wr = 1; iss_rd = rd;
    endtask

    initial begin
        reset_n = 0;
        a1 = 0; a2 = 0;
        wb_valid = 0; IsWb = 0; IsLd = 0; IsCall = 0; Rd = 0;
        aluResult = 0; ldResult = 0; PC_WB = 0;
        iss_valid = 0; iss_wr = 0; iss_rd = 0;

        // In reset: write attempt must be ignored, including its bypass.
        cyc(); a1 = 14; a2 = 0; wb(4'd0, 32'h55); issue(4'd0);
        expect_out("in_reset", 32'h0000_FFFC, 32'h0, 1'b0);
        cyc(); a1 = 0; a2 = 14;
        expect_out("in_reset_after_edge", 32'h0, 32'h0000_FFFC, 1'b0);

        // Release reset between edges.
        cyc(); reset_n = 1; a1 = 14; a2 = 0;
        expect_out("reset_values", 32'h0000_FFFC, 32'h0, 1'b0);

        // ALU write with bypass, then readback.
        cyc(); wb(4'd3, 32'h1234); a1 = 3; a2 = 14;
        expect_out("alu_bypass", 32'h1234, 32'h0000_FFFC, 1'b0);
        cyc(); a1 = 3; a2 = 0;
        expect_out("alu_readback", 32'h1234, 32'h0, 1'b0);

        // Load data wins over ALU result; r0 is writable.
        cyc(); wb(4'd0, 32'h1111); IsLd = 1; ldResult = 32'hDEAD_BEEF; a1 = 0; a2 = 3;
        expect_out("ld_bypass", 32'hDEAD_BEEF, 32'h1234, 1'b0);
        cyc(); a1 = 0; a2 = 3;
        expect_out("ld_readback_r0", 32'hDEAD_BEEF, 32'h1234, 1'b0);

        // Seed r5 and r15 so the call's effect is visible.
        cyc(); wb(4'd5, 32'h5555); a1 = 5; a2 = 0;
        expect_out("seed_r5", 32'h5555, 32'hDEAD_BEEF, 1'b0);
        cyc(); wb(4'd15, 32'hABCD); a1 = 15; a2 = 5;
        expect_out("seed_r15", 32'hABCD, 32'h5555, 1'b0);

        // Call: PC wraps, Rd ignored, ALU result ignored.
        cyc(); wb(4'd5, 32'h9999); IsCall = 1; PC_WB = 32'hFFFF_FFFC; a1 = 15; a2 = 5;
        expect_out("call_wrap_bypass", 32'h0, 32'h5555, 1'b0);
        cyc(); a1 = 15; a2 = 5;
        expect_out("call_wrap_readback", 32'h0, 32'h5555, 1'b0);
        cyc(); wb_valid = 1; IsCall = 1; IsLd = 1; ldResult = 32'h77; PC_WB = 32'h100; a1 = 0; a2 = 15;
        expect_out("call_over_ld", 32'hDEAD_BEEF, 32'h104, 1'b0);

        // Pending r7: stall until the write-back, which bypasses.
        cyc(); issue(4'd7); a1 = 7; a2 = 0;
        expect_out("issue7_same_cycle", 32'h0, 32'hDEAD_BEEF, 1'b0);
        cyc(); a1 = 7; a2 = 0;
        expect_out("pend7_stall_a", 32'h0, 32'hDEAD_BEEF, 1'b1);
        cyc(); a1 = 0; a2 = 7;
        expect_out("pend7_stall_b_port2", 32'hDEAD_BEEF, 32'h0, 1'b1);
        cyc(); wb(4'd7, 32'h7777); a1 = 7; a2 = 0;
        expect_out("pend7_wb_bypass", 32'h7777, 32'hDEAD_BEEF, 1'b0);
        cyc(); a1 = 7; a2 = 0;
        expect_out("pend7_cleared", 32'h7777, 32'hDEAD_BEEF, 1'b0);

        // Issue without iss_wr does not mark pending.
        cyc(); iss_valid = 1; iss_wr = 0; iss_rd = 8;
        cyc(); a1 = 0; a2 = 8;
        expect_out("no_wr_no_pend", 32'hDEAD_BEEF, 32'h0, 1'b0);

        // wb_valid=0 blocks write, bypass and clear.
        cyc(); issue(4'd9);
        cyc(); wb(4'd9, 32'h9999); wb_valid = 0; a1 = 9; a2 = 0;
        expect_out("wbv0_no_bypass", 32'h0, 32'hDEAD_BEEF, 1'b1);
        cyc(); a1 = 9; a2 = 0;
        expect_out("wbv0_no_clear", 32'h0, 32'hDEAD_BEEF, 1'b1);
        cyc(); wb(4'd9, 32'h9); a1 = 9; a2 = 0;
        expect_out("pend9_clear_bypass", 32'h9, 32'hDEAD_BEEF, 1'b0);

        // Same edge set and clear on r4: set wins, data still lands.
        cyc(); issue(4'd4); wb(4'd4, 32'h4444); a1 = 4; a2 = 0;
        expect_out("same_idx_bypass", 32'h4444, 32'hDEAD_BEEF, 1'b0);
        cyc(); a1 = 4; a2 = 0;
        expect_out("same_idx_set_wins", 32'h4444, 32'hDEAD_BEEF, 1'b1);
        cyc(); wb(4'd4, 32'h4445); a1 = 4; a2 = 0;
        expect_out("r4_clear", 32'h4445, 32'hDEAD_BEEF, 1'b0);

        // Different indices on one edge; write to a non-pending register.
        cyc(); issue(4'd10); wb(4'd11, 32'hBBBB);
        cyc(); a1 = 10; a2 = 11;
        expect_out("diff_idx", 32'h0, 32'hBBBB, 1'b1);
        cyc(); a1 = 11; a2 = 0;
        expect_out("nonpend_write_no_stall", 32'hBBBB, 32'hDEAD_BEEF, 1'b0);

        // Mid-run reset with r2=5 pending: immediate clear, no edge needed.
        cyc(); issue(4'd2); wb(4'd2, 32'h5);
        cyc(); a1 = 2; a2 = 14;
        expect_out("pre_reset_r2", 32'h5, 32'h0000_FFFC, 1'b1);
        cyc(); reset_n = 0; a1 = 2; a2 = 14;
        expect_out("async_reset", 32'h0, 32'h0000_FFFC, 1'b0);
        cyc(); reset_n = 1; a1 = 11; a2 = 10;
        expect_out("after_reset", 32'h0, 32'h0, 1'b0);

        cyc();
        cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, limit 50000");
        $fatal(1, "watchdog");
    end

endmodule
